// File: rtl/hazard_ctrl_if.sv
// D-stage hazard bus: register reads, downstream producer destinations and the
// stall/forward/busy responses returned by hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int TW    = 2,
    parameter int NSTG  = 3,
    parameter int CNT_W = 32
);
    logic                   is_read_rs_D;
    logic [TW-1:0]          tuse_rs_D;
    logic [REG_W-1:0]       rs_D;
    logic                   is_read_rt_D;
    logic [TW-1:0]          tuse_rt_D;
    logic [REG_W-1:0]       rt_D;
    logic                   is_mdft_D;
    logic [NSTG*REG_W-1:0]  a3_S;
    logic [NSTG*TW-1:0]     tnew_S;
    logic                   md_start_E;
    logic                   md_is_div_E;

    logic                   stall_pc;
    logic                   stall_id;
    logic                   flush_ex;
    logic [1:0]             fwd_rs_D;
    logic [1:0]             fwd_rt_D;
    logic                   md_busy;
    logic [CNT_W-1:0]       stall_cnt;

    modport master (
        output is_read_rs_D, tuse_rs_D, rs_D,
        output is_read_rt_D, tuse_rt_D, rt_D,
        output is_mdft_D, a3_S, tnew_S, md_start_E, md_is_div_E,
        input  stall_pc, stall_id, flush_ex, fwd_rs_D, fwd_rt_D, md_busy, stall_cnt
    );

    modport slave (
        input  is_read_rs_D, tuse_rs_D, rs_D,
        input  is_read_rt_D, tuse_rt_D, rt_D,
        input  is_mdft_D, a3_S, tnew_S, md_start_E, md_is_div_E,
        output stall_pc, stall_id, flush_ex, fwd_rs_D, fwd_rt_D, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/forward controller beside the D stage: Tuse/Tnew clash detection,
// lowest-stage-first forwarding, mult/div busy countdown and a stall counter.
module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int TW       = 2,
    parameter int NSTG     = 3,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic [REG_W-1:0] a3   [NSTG];
    logic [TW-1:0]    tnew [NSTG];
    logic [NSTG-1:0]  clash_rs;
    logic [NSTG-1:0]  clash_rt;
    logic             md_clash;
    logic             stall;
    logic [1:0]       fwd_rs;
    logic [1:0]       fwd_rt;

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        for (int i = 0; i < NSTG; i++) begin
            a3[i]   = hz.a3_S[i*REG_W +: REG_W];
            tnew[i] = hz.tnew_S[i*TW +: TW];
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loops can leave a value held and infer a latch.
    always_comb begin
        clash_rs = '0;
        clash_rt = '0;
        for (int i = 0; i < NSTG; i++) begin
            clash_rs[i] = hz.is_read_rs_D && (hz.rs_D == a3[i]) &&
                          (a3[i] != '0) && (hz.tuse_rs_D < tnew[i]);
            clash_rt[i] = hz.is_read_rt_D && (hz.rt_D == a3[i]) &&
                          (a3[i] != '0) && (hz.tuse_rt_D < tnew[i]);
        end
    end

    assign md_clash = hz.is_mdft_D && (hz.md_start_E || (md_cnt_q != '0));
    assign stall    = (|clash_rs) || (|clash_rt) || md_clash;

    // Walk from the oldest stage down so the youngest ready producer wins.
    always_comb begin
        fwd_rs = 2'd0;
        fwd_rt = 2'd0;
        for (int i = NSTG - 1; i >= 0; i--) begin
            if (hz.is_read_rs_D && (a3[i] == hz.rs_D) && (a3[i] != '0) && (tnew[i] == '0))
                fwd_rs = 2'(i + 1);
            if (hz.is_read_rt_D && (a3[i] == hz.rt_D) && (a3[i] != '0) && (tnew[i] == '0))
                fwd_rt = 2'(i + 1);
        end
    end

    // A start while the unit is busy is ignored; the countdown is never reloaded.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (hz.md_start_E && (md_cnt_q == '0))
            md_cnt_d = hz.md_is_div_E ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - MD_W'(1);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_pc  = stall;
    assign hz.stall_id  = stall;
    assign hz.flush_ex  = stall;
    assign hz.fwd_rs_D  = fwd_rs;
    assign hz.fwd_rt_D  = fwd_rt;
    assign hz.md_busy   = (md_cnt_q != '0);
    assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a 32-bit-counter instance plus a 4-bit-counter
// instance fed identical stimulus to observe saturation.
module tb_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int TW    = 2;
    localparam int NSTG  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(REG_W), .TW(TW), .NSTG(NSTG), .CNT_W(32)) a_if ();
    hazard_ctrl_if #(.REG_W(REG_W), .TW(TW), .NSTG(NSTG), .CNT_W(4))  b_if ();

    hazard_ctrl #(.REG_W(REG_W), .TW(TW), .NSTG(NSTG), .MULT_CYC(5), .DIV_CYC(10), .CNT_W(32))
        dut_a (.clk(clk), .reset(reset), .hz(a_if.slave));
    hazard_ctrl #(.REG_W(REG_W), .TW(TW), .NSTG(NSTG), .MULT_CYC(5), .DIV_CYC(10), .CNT_W(4))
        dut_b (.clk(clk), .reset(reset), .hz(b_if.slave));

    assign b_if.is_read_rs_D = a_if.is_read_rs_D;
    assign b_if.tuse_rs_D    = a_if.tuse_rs_D;
    assign b_if.rs_D         = a_if.rs_D;
    assign b_if.is_read_rt_D = a_if.is_read_rt_D;
    assign b_if.tuse_rt_D    = a_if.tuse_rt_D;
    assign b_if.rt_D         = a_if.rt_D;
    assign b_if.is_mdft_D    = a_if.is_mdft_D;
    assign b_if.a3_S         = a_if.a3_S;
    assign b_if.tnew_S       = a_if.tnew_S;
    assign b_if.md_start_E   = a_if.md_start_E;
    assign b_if.md_is_div_E  = a_if.md_is_div_E;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check({tag, ".stall_pc"}, 32'(a_if.stall_pc), 32'(exp));
        check({tag, ".stall_id"}, 32'(a_if.stall_id), 32'(exp));
        check({tag, ".flush_ex"}, 32'(a_if.flush_ex), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_if.is_read_rs_D = 1'b0;
        a_if.tuse_rs_D    = '0;
        a_if.rs_D         = '0;
        a_if.is_read_rt_D = 1'b0;
        a_if.tuse_rt_D    = '0;
        a_if.rt_D         = '0;
        a_if.is_mdft_D    = 1'b0;
        a_if.a3_S         = '0;
        a_if.tnew_S       = '0;
        a_if.md_start_E   = 1'b0;
        a_if.md_is_div_E  = 1'b0;
    endtask

    task automatic set_stage(input int i, input logic [REG_W-1:0] a3, input logic [TW-1:0] tn);
        a_if.a3_S[i*REG_W +: REG_W] = a3;
        a_if.tnew_S[i*TW +: TW]     = tn;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst.cnt_a", a_if.stall_cnt, 32'd0);
        check("rst.cnt_b", 32'(b_if.stall_cnt), 32'd0);
        check("rst.busy", 32'(a_if.md_busy), 32'd0);
        check_stall("rst", 1'b0);
        check("rst.fwd_rs", 32'(a_if.fwd_rs_D), 32'd0);
        check("rst.fwd_rt", 32'(a_if.fwd_rt_D), 32'd0);

        // Load-use: E produces r8 two cycles late, D needs it now
        a_if.is_read_rs_D = 1'b1;
        a_if.rs_D = 5'd8;
        a_if.tuse_rs_D = 2'd0;
        set_stage(0, 5'd8, 2'd2);
        #1;
        check_stall("lu", 1'b1);
        check("lu.fwd_rs", 32'(a_if.fwd_rs_D), 32'd0);
        check("lu.cnt0", a_if.stall_cnt, 32'd0);
        tick();
        check("lu.cnt1", a_if.stall_cnt, 32'd1);
        tick();
        check("lu.cnt2", a_if.stall_cnt, 32'd2);
        set_stage(0, 5'd0, 2'd0);
        set_stage(1, 5'd8, 2'd0);
        #1;
        check_stall("lu_m", 1'b0);
        check("lu_m.fwd_rs", 32'(a_if.fwd_rs_D), 32'd2);
        tick();
        check("lu_m.cnt", a_if.stall_cnt, 32'd2);

        // Pending match with tuse >= tnew: no stall, no forward yet
        a_if.tuse_rs_D = 2'd1;
        set_stage(1, 5'd0, 2'd0);
        set_stage(0, 5'd8, 2'd1);
        #1;
        check_stall("late", 1'b0);
        check("late.fwd_rs", 32'(a_if.fwd_rs_D), 32'd0);
        set_stage(0, 5'd8, 2'd2);
        #1;
        check_stall("late2", 1'b1);
        tick();
        check("late2.cnt", a_if.stall_cnt, 32'd3);

        // Priority: r9 ready in E, M and W
        idle();
        a_if.is_read_rt_D = 1'b1;
        a_if.rt_D = 5'd9;
        set_stage(0, 5'd9, 2'd0);
        set_stage(1, 5'd9, 2'd0);
        set_stage(2, 5'd9, 2'd0);
        #1;
        check("prio.fwd_rt", 32'(a_if.fwd_rt_D), 32'd1);
        check_stall("prio", 1'b0);
        set_stage(0, 5'd3, 2'd0);
        #1;
        check("prio_m.fwd_rt", 32'(a_if.fwd_rt_D), 32'd2);
        set_stage(1, 5'd3, 2'd0);
        #1;
        check("prio_w.fwd_rt", 32'(a_if.fwd_rt_D), 32'd3);
        a_if.is_read_rt_D = 1'b0;
        #1;
        check("noread.fwd_rt", 32'(a_if.fwd_rt_D), 32'd0);
        check_stall("noread", 1'b0);

        // $zero never clashes or forwards
        idle();
        a_if.is_read_rs_D = 1'b1;
        a_if.rs_D = 5'd0;
        set_stage(0, 5'd0, 2'd2);
        set_stage(1, 5'd0, 2'd0);
        #1;
        check_stall("zero", 1'b0);
        check("zero.fwd_rs", 32'(a_if.fwd_rs_D), 32'd0);

        // Rs and Rt clash together: one stall, counter +1
        idle();
        a_if.is_read_rs_D = 1'b1;
        a_if.rs_D = 5'd4;
        a_if.is_read_rt_D = 1'b1;
        a_if.rt_D = 5'd5;
        set_stage(0, 5'd4, 2'd2);
        set_stage(1, 5'd5, 2'd2);
        #1;
        check_stall("dual", 1'b1);
        check("dual.fwd_rs", 32'(a_if.fwd_rs_D), 32'd0);
        check("dual.fwd_rt", 32'(a_if.fwd_rt_D), 32'd0);
        tick();
        idle();
        check("dual.cnt", a_if.stall_cnt, 32'd4);

        // Divide with MD instruction in D, plus a register clash in cycle 0
        a_if.is_mdft_D = 1'b1;
        a_if.md_start_E = 1'b1;
        a_if.md_is_div_E = 1'b1;
        a_if.is_read_rs_D = 1'b1;
        a_if.rs_D = 5'd8;
        set_stage(0, 5'd8, 2'd2);
        #1;
        check_stall("div0", 1'b1);
        check("div0.busy", 32'(a_if.md_busy), 32'd0);
        tick();
        a_if.md_start_E = 1'b0;
        a_if.md_is_div_E = 1'b0;
        set_stage(0, 5'd0, 2'd0);
        for (int k = 1; k <= 11; k++) begin
            #1;
            check($sformatf("div%0d.busy", k), 32'(a_if.md_busy), (k <= 10) ? 32'd1 : 32'd0);
            check($sformatf("div%0d.stall", k), 32'(a_if.stall_pc), (k <= 10) ? 32'd1 : 32'd0);
            tick();
        end
        check("div.cnt_a", a_if.stall_cnt, 32'd15);
        check("div.cnt_b", 32'(b_if.stall_cnt), 32'd15);

        // Multiply: busy cycles 1..5
        idle();
        a_if.is_mdft_D = 1'b1;
        a_if.md_start_E = 1'b1;
        #1;
        check_stall("mul0", 1'b1);
        tick();
        a_if.md_start_E = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            check($sformatf("mul%0d.busy", k), 32'(a_if.md_busy), (k <= 5) ? 32'd1 : 32'd0);
            check($sformatf("mul%0d.stall", k), 32'(a_if.stall_pc), (k <= 5) ? 32'd1 : 32'd0);
            tick();
        end
        check("mul.cnt_a", a_if.stall_cnt, 32'd21);
        check("mul.cnt_b_sat", 32'(b_if.stall_cnt), 32'd15);

        // Reset mid-divide, with md_start_E held during reset
        idle();
        a_if.md_start_E = 1'b1;
        a_if.md_is_div_E = 1'b1;
        tick();
        a_if.md_start_E = 1'b0;
        tick();
        tick();
        tick();
        check("rdiv4.busy", 32'(a_if.md_busy), 32'd1);
        reset = 1'b1;
        a_if.md_start_E = 1'b1;
        tick();
        reset = 1'b0;
        a_if.md_start_E = 1'b0;
        a_if.md_is_div_E = 1'b0;
        #1;
        check("rdiv5.busy", 32'(a_if.md_busy), 32'd0);
        check("rdiv5.cnt_a", a_if.stall_cnt, 32'd0);
        check("rdiv5.cnt_b", 32'(b_if.stall_cnt), 32'd0);
        tick();
        check("rdiv6.busy", 32'(a_if.md_busy), 32'd0);

        // Saturation: 20 stalled cycles
        a_if.is_read_rs_D = 1'b1;
        a_if.rs_D = 5'd8;
        set_stage(0, 5'd8, 2'd2);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) check("sat14.cnt_b", 32'(b_if.stall_cnt), 32'd14);
        end
        check("sat.cnt_a", a_if.stall_cnt, 32'd20);
        check("sat.cnt_b", 32'(b_if.stall_cnt), 32'd15);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
